// File: rtl/pfengine_sched.sv
// pfengine_sched
// Prefetch dispatch scheduler. Accepts one multi-line prefetch op at a time
// from the prefetch generator and expands it into sequential line requests.
// Each line goes to pipe 0 or pipe 1 according to its address bit 0, and up
// to two lines are issued per cycle. Saturating issue and drop statistics are
// also kept.
//
// Ports
//   clk, reset (async, active-low)
//   pfgtopfe_op_*          op input: valid, retry (out), line, count, l2
//   pftodc_req{0,1}_*      DC request pipes: valid (out), retry (in), line (out)
//   pftol2_req{0,1}_*      L2 request pipes: valid (out), retry (in), line (out)
//   pf_issued_dc/l2        saturating count of lines transferred per target
//   pf_dropped             saturating count of ops accepted with count 0
module pfengine_sched #(
   parameter int LINE_W = 38,
   parameter int STAT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pfgtopfe_op_valid,
   output logic              pfgtopfe_op_retry,
   input  logic [LINE_W-1:0] pfgtopfe_op_line,
   input  logic [2:0]        pfgtopfe_op_count,
   input  logic              pfgtopfe_op_l2,
   output logic              pftodc_req0_valid,
   input  logic              pftodc_req0_retry,
   output logic [LINE_W-1:0] pftodc_req0_line,
   output logic              pftodc_req1_valid,
   input  logic              pftodc_req1_retry,
   output logic [LINE_W-1:0] pftodc_req1_line,
   output logic              pftol2_req0_valid,
   input  logic              pftol2_req0_retry,
   output logic [LINE_W-1:0] pftol2_req0_line,
   output logic              pftol2_req1_valid,
   input  logic              pftol2_req1_retry,
   output logic [LINE_W-1:0] pftol2_req1_line,
   output logic [STAT_W-1:0] pf_issued_dc,
   output logic [STAT_W-1:0] pf_issued_l2,
   output logic [STAT_W-1:0] pf_dropped
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_stateNext;
   logic [LINE_W-1:0] r_cur;
   logic [LINE_W-1:0] w_curNext;
   logic [2:0]        r_rem;
   logic [2:0]        w_remNext;
   logic              r_tgt;
   logic              w_tgtNext;
   logic              r_nxtDone;
   logic              w_nxtDoneNext;

   logic [STAT_W-1:0] r_issuedDc;
   logic [STAT_W-1:0] r_issuedL2;
   logic [STAT_W-1:0] r_dropped;

   logic [LINE_W-1:0] w_nxtLine;
   logic              w_presCur;
   logic              w_presNxt;
   logic [1:0]        w_pipeValid;
   logic [1:0]        w_pipeRetry;
   logic [1:0]        w_pipeXfer;
   logic [LINE_W-1:0] w_pipeLine0;
   logic [LINE_W-1:0] w_pipeLine1;
   logic              w_curXfer;
   logic              w_nxtXfer;
   logic [1:0]        w_xferCount;
   logic [1:0]        w_dcAdd;
   logic [1:0]        w_l2Add;
   logic              w_accept;
   logic              w_dropNow;

   // Saturating add of a 0..2 increment; the extra top bit of the sum
   // catches the overflow past the all-ones ceiling.
   function automatic logic [STAT_W-1:0] satAdd(input logic [STAT_W-1:0] a,
                                                input logic [1:0]        n);
      logic [STAT_W:0] s;
      s = {1'b0, a} + {{(STAT_W-1){1'b0}}, n};
      return s[STAT_W] ? {STAT_W{1'b1}} : s[STAT_W-1:0];
   endfunction

   // Request decode works only from registered state so that no retry input
   // can reach a valid or line output. The line at cur always sits on pipe
   // cur[0]; its successor (if presented) sits on the opposite pipe. Which
   // family is driven is chosen by the latched target, while the retry that
   // matters for each pipe comes from that same family.
   always_comb begin
      w_nxtLine      = r_cur + LINE_W'(1);
      w_presCur      = (r_state == ST_ISSUE);
      w_presNxt      = w_presCur && (r_rem >= 3'd2) && !r_nxtDone;
      w_pipeValid[0] = r_cur[0] ? w_presNxt : w_presCur;
      w_pipeValid[1] = r_cur[0] ? w_presCur : w_presNxt;
      w_pipeLine0    = r_cur[0] ? w_nxtLine : r_cur;
      w_pipeLine1    = r_cur[0] ? r_cur : w_nxtLine;
      w_pipeRetry[0] = r_tgt ? pftol2_req0_retry : pftodc_req0_retry;
      w_pipeRetry[1] = r_tgt ? pftol2_req1_retry : pftodc_req1_retry;
      w_pipeXfer     = w_pipeValid & ~w_pipeRetry;
      w_curXfer      = r_cur[0] ? w_pipeXfer[1] : w_pipeXfer[0];
      w_nxtXfer      = r_cur[0] ? w_pipeXfer[0] : w_pipeXfer[1];
      w_xferCount    = {1'b0, w_curXfer} + {1'b0, w_nxtXfer};
      w_dcAdd        = r_tgt ? 2'd0 : w_xferCount;
      w_l2Add        = r_tgt ? w_xferCount : 2'd0;
      w_accept       = (r_state == ST_IDLE) && pfgtopfe_op_valid && (pfgtopfe_op_count != 3'd0);
      w_dropNow      = (r_state == ST_IDLE) && pfgtopfe_op_valid && (pfgtopfe_op_count == 3'd0);

      pfgtopfe_op_retry = (r_state == ST_ISSUE);
      pftodc_req0_valid = w_pipeValid[0] && !r_tgt;
      pftodc_req1_valid = w_pipeValid[1] && !r_tgt;
      pftol2_req0_valid = w_pipeValid[0] && r_tgt;
      pftol2_req1_valid = w_pipeValid[1] && r_tgt;
      pftodc_req0_line  = w_pipeLine0;
      pftodc_req1_line  = w_pipeLine1;
      pftol2_req0_line  = w_pipeLine0;
      pftol2_req1_line  = w_pipeLine1;
      pf_issued_dc      = r_issuedDc;
      pf_issued_l2      = r_issuedL2;
      pf_dropped        = r_dropped;
   end

   // Next-state logic. When only cur goes through, the retried successor
   // becomes the new cur, and since cur+1 has the opposite bit 0 it lands on
   // the very pipe it was already on, keeping it valid and stable. When only
   // the successor goes through, nxt_done remembers it so it is not offered
   // again, and the pair retires together once cur finally transfers.
   always_comb begin
      w_stateNext   = r_state;
      w_curNext     = r_cur;
      w_remNext     = r_rem;
      w_tgtNext     = r_tgt;
      w_nxtDoneNext = r_nxtDone;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_curNext     = pfgtopfe_op_line;
               w_remNext     = pfgtopfe_op_count;
               w_tgtNext     = pfgtopfe_op_l2;
               w_nxtDoneNext = 1'b0;
               w_stateNext   = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (w_curXfer && (w_nxtXfer || r_nxtDone)) begin
               w_curNext     = r_cur + LINE_W'(2);
               w_remNext     = r_rem - 3'd2;
               w_nxtDoneNext = 1'b0;
            end else if (w_curXfer) begin
               w_curNext = w_nxtLine;
               w_remNext = r_rem - 3'd1;
            end else if (w_nxtXfer) begin
               w_nxtDoneNext = 1'b1;
            end
            if (w_remNext == 3'd0) begin
               w_stateNext = ST_IDLE;
            end
         end
         default: w_stateNext = ST_IDLE;
      endcase
   end

   // State and statistics registers. Reset discards any in-flight op.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_cur      <= '0;
         r_rem      <= '0;
         r_tgt      <= 1'b0;
         r_nxtDone  <= 1'b0;
         r_issuedDc <= '0;
         r_issuedL2 <= '0;
         r_dropped  <= '0;
      end else begin
         r_state    <= w_stateNext;
         r_cur      <= w_curNext;
         r_rem      <= w_remNext;
         r_tgt      <= w_tgtNext;
         r_nxtDone  <= w_nxtDoneNext;
         r_issuedDc <= satAdd(r_issuedDc, w_dcAdd);
         r_issuedL2 <= satAdd(r_issuedL2, w_l2Add);
         r_dropped  <= satAdd(r_dropped, {1'b0, w_dropNow});
      end
   end

endmodule

// File: tb/tb_pfengine_sched.sv
// tb_pfengine_sched
// Scoreboard bench for pfengine_sched. Each accepted op is expanded by the
// bench into its list of lines (line, line+1, ... modulo 2^LINE_W) and pushed
// into an expected queue; a monitor pops lines as the DUT transfers them and
// checks pipe (bit 0) and family. Statistics are modelled per op with
// saturation. A small counter width makes saturation reachable.
module tb_pfengine_sched;

   localparam int LINE_W   = 38;
   localparam int STAT_W   = 4;
   localparam int STAT_MAX = (1 << STAT_W) - 1;

   typedef struct packed {
      logic [LINE_W-1:0] line;
      logic              l2;
   } expT;

   logic              clk;
   logic              reset;
   logic              opValid;
   logic              opRetry;
   logic [LINE_W-1:0] opLine;
   logic [2:0]        opCount;
   logic              opL2;
   logic              dcV0, dcV1, dcR0, dcR1;
   logic [LINE_W-1:0] dcL0, dcL1;
   logic              l2V0, l2V1, l2R0, l2R1;
   logic [LINE_W-1:0] l2L0, l2L1;
   logic [STAT_W-1:0] issuedDc, issuedL2, dropped;

   int assertCount = 0;
   int failCount   = 0;

   expT expQ[$];
   int  mIssuedDc = 0;
   int  mIssuedL2 = 0;
   int  mDropped  = 0;

   // retryMode: 0 random, 1 none, 2 forced pattern for forceCycles cycles
   int       retryMode   = 1;
   logic [3:0] forced    = 4'b0000;
   int       forceCycles = 0;

   pfengine_sched #(.LINE_W(LINE_W), .STAT_W(STAT_W)) dut (
      .clk               (clk),
      .reset             (reset),
      .pfgtopfe_op_valid (opValid),
      .pfgtopfe_op_retry (opRetry),
      .pfgtopfe_op_line  (opLine),
      .pfgtopfe_op_count (opCount),
      .pfgtopfe_op_l2    (opL2),
      .pftodc_req0_valid (dcV0),
      .pftodc_req0_retry (dcR0),
      .pftodc_req0_line  (dcL0),
      .pftodc_req1_valid (dcV1),
      .pftodc_req1_retry (dcR1),
      .pftodc_req1_line  (dcL1),
      .pftol2_req0_valid (l2V0),
      .pftol2_req0_retry (l2R0),
      .pftol2_req0_line  (l2L0),
      .pftol2_req1_valid (l2V1),
      .pftol2_req1_retry (l2R1),
      .pftol2_req1_line  (l2L1),
      .pf_issued_dc      (issuedDc),
      .pf_issued_l2      (issuedL2),
      .pf_dropped        (dropped)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something wedges beyond every bounded wait.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got simulation still running, required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
      end
   endtask

   function automatic int satInc(input int x, input int n);
      return (x + n > STAT_MAX) ? STAT_MAX : x + n;
   endfunction

   // Retry driver: updates all four retry inputs 1 unit after each rising
   // edge, so main-thread actions (at +2) never race it.
   initial begin
      {l2R1, l2R0, dcR1, dcR0} = 4'b0000;
      forever begin
         @(posedge clk);
         #1;
         case (retryMode)
            0: begin
               dcR0 = ($urandom_range(0, 3) == 0);
               dcR1 = ($urandom_range(0, 3) == 0);
               l2R0 = ($urandom_range(0, 3) == 0);
               l2R1 = ($urandom_range(0, 3) == 0);
            end
            2: begin
               if (forceCycles > 0) begin
                  {l2R1, l2R0, dcR1, dcR0} = forced;
                  forceCycles--;
               end else begin
                  {l2R1, l2R0, dcR1, dcR0} = 4'b0000;
               end
            end
            default: {l2R1, l2R0, dcR1, dcR0} = 4'b0000;
         endcase
      end
   end

   // Monitor: on every falling edge, pop each transferred line from the
   // expected queue and check protocol rules (one family at a time, a
   // retried request stays valid with the same line).
   logic [3:0]        monV, monR, prevHold;
   logic [LINE_W-1:0] monLn [4];
   logic [LINE_W-1:0] prevLine [4];
   int                monIdx;

   initial prevHold = 4'b0000;

   always @(negedge clk) begin
      if (!reset) begin
         prevHold = 4'b0000;
      end else begin
         monV = {l2V1, l2V0, dcV1, dcV0};
         monR = {l2R1, l2R0, dcR1, dcR0};
         monLn[0] = dcL0; monLn[1] = dcL1; monLn[2] = l2L0; monLn[3] = l2L1;
         if (monV != 4'b0000)
            checkOutput("familyExcl", 64'((|monV[1:0]) && (|monV[3:2])), 64'd0);
         for (int p = 0; p < 4; p++) begin
            if (prevHold[p]) begin
               checkOutput("holdValid", 64'(monV[p]), 64'd1);
               checkOutput("holdLine", 64'(monLn[p]), 64'(prevLine[p]));
            end
            if (monV[p] && !monR[p]) begin
               monIdx = -1;
               for (int k = 0; k < 2 && k < expQ.size(); k++) begin
                  if (expQ[k].line == monLn[p]) begin
                     monIdx = k;
                     break;
                  end
               end
               checkOutput("xferExpected", 64'(monIdx >= 0), 64'd1);
               if (monIdx >= 0) begin
                  checkOutput("xferPipe", 64'(p % 2), 64'(expQ[monIdx].line[0]));
                  checkOutput("xferFamily", 64'(p / 2), 64'(expQ[monIdx].l2));
                  expQ.delete(monIdx);
               end
            end
            prevHold[p] = monV[p] && monR[p];
            prevLine[p] = monLn[p];
         end
      end
   end

   task automatic checkCounters(input string tag);
      checkOutput({tag, "_issuedDc"}, 64'(issuedDc), 64'(mIssuedDc));
      checkOutput({tag, "_issuedL2"}, 64'(issuedL2), 64'(mIssuedL2));
      checkOutput({tag, "_dropped"}, 64'(dropped), 64'(mDropped));
   endtask

   // Offer one op and wait (bounded) for all its lines to transfer.
   // Called and returns at 2 units after a rising edge.
   // expCycles < 0 skips the ISSUE-length check.
   task automatic applyStimulus(input logic [LINE_W-1:0] line, input int count,
                                input logic l2, input int expCycles);
      expT e;
      int  cycles;
      logic [63:0] rnd;
      opValid = 1'b1;
      opLine  = line;
      opCount = 3'(count);
      opL2    = l2;
      checkOutput("opRetryIdle", 64'(opRetry), 64'd0);
      @(posedge clk);
      #2;
      opValid = 1'b0;
      rnd     = {$urandom, $urandom};
      opLine  = rnd[LINE_W-1:0];
      opCount = 3'($urandom_range(0, 7));
      if (count == 0) begin
         mDropped = satInc(mDropped, 1);
         checkOutput("dropNoValid", 64'({l2V1, l2V0, dcV1, dcV0}), 64'd0);
         checkOutput("dropOpRetry", 64'(opRetry), 64'd0);
         checkCounters("drop");
      end else begin
         for (int k = 0; k < count; k++) begin
            e.line = line + LINE_W'(k);
            e.l2   = l2;
            expQ.push_back(e);
         end
         if (l2) mIssuedL2 = satInc(mIssuedL2, count);
         else    mIssuedDc = satInc(mIssuedDc, count);
         checkOutput("firstValid", 64'(l2 ? (l2V0 | l2V1) : (dcV0 | dcV1)), 64'd1);
         checkOutput("opRetryBusy", 64'(opRetry), 64'd1);
         cycles = 0;
         while (expQ.size() != 0 && cycles < 400) begin
            @(posedge clk);
            #2;
            cycles++;
         end
         checkOutput("opComplete", 64'(expQ.size()), 64'd0);
         expQ.delete();
         checkOutput("opRetryDone", 64'(opRetry), 64'd0);
         if (expCycles >= 0)
            checkOutput("issueCycles", 64'(cycles), 64'(expCycles));
         checkCounters("op");
      end
   endtask

   task automatic pulseReset();
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      mIssuedDc = 0;
      mIssuedL2 = 0;
      mDropped  = 0;
      expQ.delete();
      checkOutput("rstValids", 64'({l2V1, l2V0, dcV1, dcV0}), 64'd0);
      checkOutput("rstOpRetry", 64'(opRetry), 64'd0);
      checkCounters("rst");
      @(posedge clk);
      #2;
      reset = 1'b1;
   endtask

   initial begin
      logic [63:0]       rnd;
      logic [LINE_W-1:0] allOnes;
      int                cnt;
      allOnes = '1;
      reset   = 1'b0;
      opValid = 1'b0;
      opLine  = '0;
      opCount = 3'd0;
      opL2    = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      checkOutput("resetValids", 64'({l2V1, l2V0, dcV1, dcV0}), 64'd0);
      checkOutput("resetOpRetry", 64'(opRetry), 64'd0);
      checkCounters("reset");
      reset = 1'b1;

      // Basic split and odd-start L2 op, no back-pressure.
      retryMode = 1;
      applyStimulus(LINE_W'('h100), 4, 1'b0, 2);
      applyStimulus(LINE_W'('h201), 3, 1'b1, 2);

      // Pipe 1 retried 3 cycles, then pipe 0 retried 3 cycles.
      retryMode   = 2;
      forced      = 4'b0010;
      forceCycles = 3;
      applyStimulus(LINE_W'('h10), 2, 1'b0, 4);
      forced      = 4'b0001;
      forceCycles = 3;
      applyStimulus(LINE_W'('h10), 2, 1'b0, 4);
      retryMode = 1;

      // Drop, then a pair that wraps from all-ones to zero in one cycle.
      applyStimulus(LINE_W'('h55), 0, 1'b0, -1);
      applyStimulus(allOnes, 2, 1'b0, 1);

      // Reset in the third cycle of a fully back-pressured 7-line op.
      retryMode   = 2;
      forced      = 4'b1111;
      forceCycles = 1000;
      opValid = 1'b1;
      opLine  = LINE_W'('h300);
      opCount = 3'd7;
      opL2    = 1'b0;
      @(posedge clk);
      #2;
      opValid = 1'b0;
      checkOutput("midOpRetry", 64'(opRetry), 64'd1);
      repeat (2) begin
         @(posedge clk);
         #2;
      end
      reset = 1'b0;
      #1;
      mIssuedDc = 0;
      mIssuedL2 = 0;
      mDropped  = 0;
      checkOutput("midRstValids", 64'({l2V1, l2V0, dcV1, dcV0}), 64'd0);
      checkOutput("midRstOpRetry", 64'(opRetry), 64'd0);
      checkCounters("midRst");
      forceCycles = 0;
      retryMode   = 1;
      @(posedge clk);
      #2;
      reset = 1'b1;
      applyStimulus(LINE_W'('h40), 5, 1'b1, 3);

      // 20 DC lines: the 4-bit counter has to stop at 15.
      applyStimulus(LINE_W'('h1000), 7, 1'b0, 4);
      applyStimulus(LINE_W'('h2001), 7, 1'b0, 4);
      applyStimulus(LINE_W'('h3000), 6, 1'b0, 3);
      checkOutput("saturatedDc", 64'(issuedDc), 64'(STAT_MAX));

      // Random ops under random or absent back-pressure.
      for (int i = 0; i < 40; i++) begin
         if (i % 10 == 0) pulseReset();
         retryMode = ($urandom_range(0, 2) == 0) ? 1 : 0;
         rnd = {$urandom, $urandom};
         if ($urandom_range(0, 4) == 0) rnd[LINE_W-1:3] = '1;
         cnt = $urandom_range(0, 7);
         applyStimulus(rnd[LINE_W-1:0], cnt, 1'($urandom_range(0, 1)),
                       (retryMode == 1) ? (cnt + 1) / 2 : -1);
      end
      retryMode = 1;

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
